// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arbitrating mux: mode encodings, default sizes
// and the pointer-wrap helper used by the round-robin logic.
package arb_mux_pkg;

    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FIXED = 1'b1
    } mode_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_N     = 4;
    localparam int DEFAULT_SEL_W = 2;

    // Index following idx in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arb_mux_if.sv
// Channel-side and output-side handshake bundle of arb_mux.
// Handshake: a word moves when valid and ready are both high at a rising CLK edge.
interface arb_mux_if
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    parameter int SEL_W = DEFAULT_SEL_W
) ();

    logic               MODE;
    logic [SEL_W-1:0]   S;
    logic [N*WIDTH-1:0] I_DATA;
    logic [N-1:0]       I_VALID;
    logic [N-1:0]       I_READY;
    logic [WIDTH-1:0]   O_DATA;
    logic               O_VALID;
    logic               O_READY;
    logic [SEL_W-1:0]   O_SEL;

    modport slave (
        input  MODE, S, I_DATA, I_VALID, O_READY,
        output I_READY, O_DATA, O_VALID, O_SEL
    );

    modport master (
        output MODE, S, I_DATA, I_VALID, O_READY,
        input  I_READY, O_DATA, O_VALID, O_SEL
    );

endinterface

// File: rtl/arb_mux_rr_grant.sv
// Rotating-priority search: grants the first requester at or above i_ptr,
// wrapping from N-1 back to 0.
module rr_grant
    import arb_mux_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int SEL_W = DEFAULT_SEL_W
) (
    input  logic [N-1:0]     i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        logic w_found;
        int   w_k;
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_k = int'(i_ptr) + i;
            if (w_k >= N) w_k = w_k - N;
            if (!w_found && i_req[w_k]) begin
                o_gnt[w_k] = 1'b1;
                o_idx      = SEL_W'(w_k);
                w_found    = 1'b1;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrating mux with a single registered output entry; round-robin
// or fixed-select arbitration, full throughput when downstream is ready.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    parameter int SEL_W = DEFAULT_SEL_W
) (
    input  logic             CLK,
    input  logic             RST,
    arb_mux_if.slave         bus,
    output logic [SEL_W-1:0] o_dbg_ptr
);

    logic [N-1:0]     w_rr_gnt;
    logic [N-1:0]     w_fix_gnt;
    logic [N-1:0]     w_gnt;
    logic [SEL_W-1:0] w_rr_idx;
    logic [SEL_W-1:0] w_idx;
    logic             w_rr_any;
    logic             w_fixed;
    logic             w_can_load;
    logic             w_xfer;
    logic [WIDTH-1:0] w_data;

    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_sel;
    logic             r_valid;
    logic [SEL_W-1:0] r_ptr;

    rr_grant #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_grant (
        .i_req (bus.I_VALID),
        .i_ptr (r_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx),
        .o_any (w_rr_any)
    );

    // A select value with no matching channel (S >= N) simply matches nothing.
    always_comb begin
        w_fix_gnt = '0;
        for (int k = 0; k < N; k++) begin
            if (bus.S == SEL_W'(k)) w_fix_gnt[k] = bus.I_VALID[k];
        end
    end

    assign w_fixed    = (bus.MODE == MODE_FIXED);
    assign w_gnt      = w_fixed ? w_fix_gnt : w_rr_gnt;
    assign w_idx      = w_fixed ? bus.S : w_rr_idx;
    assign w_can_load = !r_valid || bus.O_READY;
    assign w_xfer     = RST && w_can_load && (|w_gnt);
    assign w_data     = bus.I_DATA[int'(w_idx)*WIDTH +: WIDTH];

    assign bus.I_READY = (RST && w_can_load) ? w_gnt : '0;
    assign bus.O_DATA  = r_data;
    assign bus.O_VALID = r_valid;
    assign bus.O_SEL   = r_sel;
    assign o_dbg_ptr   = r_ptr;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data  <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else if (w_xfer) begin
            r_data  <= w_data;
            r_sel   <= w_idx;
            r_valid <= 1'b1;
            if (!w_fixed) r_ptr <= SEL_W'(wrap_inc(int'(w_idx), N));
        end else if (bus.O_READY) begin
            r_valid <= 1'b0;
        end
    end

    logic w_unused;
    assign w_unused = w_rr_any;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: directed scenarios plus random traffic, checked against
// a spec-level grant model and an output scoreboard.
module tb_arb_mux;
    import arb_mux_pkg::*;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int SEL_W = 2;
    localparam int W     = SEL_W + WIDTH;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    arb_mux_if #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) bus ();
    logic [SEL_W-1:0] dbg_ptr;
    arb_mux #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .o_dbg_ptr (dbg_ptr)
    );

    // Non-power-of-two instance so a select value >= N can be exercised.
    arb_mux_if #(.WIDTH(8), .N(3), .SEL_W(2)) bus3 ();
    logic [1:0] dbg_ptr3;
    arb_mux #(.WIDTH(8), .N(3), .SEL_W(2)) dut3 (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus3),
        .o_dbg_ptr (dbg_ptr3)
    );

    int             checks   = 0;
    int             failures = 0;
    logic [W-1:0]   exp_q[$];
    int             m_ptr    = 0;
    bit             m_valid  = 1'b0;
    bit             pin_en   = 1'b0;
    logic [WIDTH-1:0] pin_val = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Grant straight from the arbitration rules: fixed picks S if it is a
    // requesting channel, round-robin scans upward from the pointer.
    function automatic int model_grant(input bit mode, input int s, input logic [N-1:0] v, input int ptr);
        if (mode) begin
            if (s < N && v[s]) return s;
            return -1;
        end
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic drive_cycle(input bit mode, input int s, input logic [N-1:0] v, input bit rdy);
        logic [WIDTH-1:0] dat[N];
        logic [N-1:0]     exp_rdy;
        int               g;
        bit               can_load;
        @(negedge CLK);
        for (int k = 0; k < N; k++) dat[k] = WIDTH'($urandom);
        if (pin_en) dat[2] = pin_val;
        bus.MODE    = mode;
        bus.S       = SEL_W'(s);
        bus.I_VALID = v;
        bus.O_READY = rdy;
        for (int k = 0; k < N; k++) bus.I_DATA[k*WIDTH +: WIDTH] = dat[k];
        #2;
        g        = model_grant(mode, s, v, m_ptr);
        can_load = !m_valid || rdy;
        exp_rdy  = (can_load && g >= 0) ? (N'(1) << g) : '0;
        check("i_ready", 64'(bus.I_READY), 64'(exp_rdy));
        check("o_valid", 64'(bus.O_VALID), 64'(m_valid));
        check("ptr", 64'(dbg_ptr), 64'(m_ptr));
        if (can_load && g >= 0) begin
            exp_q.push_back({SEL_W'(g), dat[g]});
            m_valid = 1'b1;
            if (!mode) m_ptr = (g + 1) % N;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
    endtask

    // Monitor: compares every drained word and checks stability while stalled.
    initial begin
        logic [W-1:0]     exp;
        logic             prev_hold;
        logic [WIDTH-1:0] pd;
        logic [SEL_W-1:0] ps;
        prev_hold = 1'b0;
        pd = '0;
        ps = '0;
        forever begin
            @(negedge CLK);
            #4;
            if (!RST) begin
                prev_hold = 1'b0;
                continue;
            end
            if (prev_hold) begin
                check("hold_data", 64'(bus.O_DATA), 64'(pd));
                check("hold_sel", 64'(bus.O_SEL), 64'(ps));
                check("hold_valid", 64'(bus.O_VALID), 64'(1));
            end
            if (bus.O_VALID && bus.O_READY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got sel %0d data %0h expected none at %0t",
                             bus.O_SEL, bus.O_DATA, $time);
                end else begin
                    exp = exp_q.pop_front();
                    check("out_sel", 64'(bus.O_SEL), 64'(exp[W-1:WIDTH]));
                    check("out_data", 64'(bus.O_DATA), 64'(exp[WIDTH-1:0]));
                end
            end
            prev_hold = bus.O_VALID && !bus.O_READY;
            pd        = bus.O_DATA;
            ps        = bus.O_SEL;
        end
    end

    initial begin
        bus.MODE     = 1'b0;
        bus.S        = '0;
        bus.I_DATA   = '0;
        bus.I_VALID  = '0;
        bus.O_READY  = 1'b0;
        bus3.MODE    = 1'b1;
        bus3.S       = 2'd3;
        bus3.I_DATA  = 24'hA5C33C;
        bus3.I_VALID = 3'b111;
        bus3.O_READY = 1'b1;

        #1;
        check("rst_o_valid", 64'(bus.O_VALID), 64'(0));
        check("rst_o_data", 64'(bus.O_DATA), 64'(0));
        check("rst_o_sel", 64'(bus.O_SEL), 64'(0));
        check("rst_ptr", 64'(dbg_ptr), 64'(0));
        repeat (3) @(negedge CLK);
        RST = 1'b1;

        // All channels requesting, always ready: sel walks 0,1,2,3,0.
        repeat (5) drive_cycle(1'b0, 0, 4'b1111, 1'b1);

        // Park the pointer at 3, then requests 0 and 2 are served in that order.
        drive_cycle(1'b0, 0, 4'b0100, 1'b1);
        repeat (2) drive_cycle(1'b0, 0, 4'b0101, 1'b1);
        drive_cycle(1'b0, 0, 4'b0000, 1'b1);
        check("ptr_after_0101", 64'(dbg_ptr), 64'(3));

        // Fixed select of channel 2 carrying a known word.
        pin_en  = 1'b1;
        pin_val = 32'hDEADBEEF;
        drive_cycle(1'b1, 2, 4'b1111, 1'b1);
        pin_en  = 1'b0;
        drive_cycle(1'b0, 0, 4'b0000, 1'b0);

        // Backpressure for three cycles, then drain and reload on one edge.
        drive_cycle(1'b0, 0, 4'b1111, 1'b0);
        repeat (3) drive_cycle(1'b0, 0, 4'b1111, 1'b0);
        repeat (2) drive_cycle(1'b0, 0, 4'b1111, 1'b1);

        // Out-of-range fixed select on the 3-channel instance never grants.
        repeat (8) begin
            drive_cycle(1'b0, 0, 4'b0000, 1'b1);
            check("sel_oob_i_ready", 64'(bus3.I_READY), 64'(0));
            check("sel_oob_o_valid", 64'(bus3.O_VALID), 64'(0));
        end

        repeat (400) begin
            drive_cycle(($urandom_range(0, 3) == 0), int'($urandom_range(0, N-1)),
                        N'($urandom), ($urandom_range(0, 9) < 7));
        end

        // Asynchronous reset between edges while a word is held.
        drive_cycle(1'b0, 0, 4'b1111, 1'b0);
        drive_cycle(1'b0, 0, 4'b1111, 1'b0);
        @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("arst_o_valid", 64'(bus.O_VALID), 64'(0));
        check("arst_o_data", 64'(bus.O_DATA), 64'(0));
        check("arst_o_sel", 64'(bus.O_SEL), 64'(0));
        check("arst_i_ready", 64'(bus.I_READY), 64'(0));
        exp_q.delete();
        m_valid = 1'b0;
        m_ptr   = 0;
        bus.I_VALID = '0;
        bus.O_READY = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        drive_cycle(1'b0, 0, 4'b1010, 1'b1);
        drive_cycle(1'b0, 0, 4'b1111, 1'b1);

        repeat (3) drive_cycle(1'b0, 0, 4'b0000, 1'b1);
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
